sync_acq_ctrl: RTL

- Acquisition/tracking controller that sequences the correlation sync detector.
- Drives detector enable and threshold, and times detector sop pulses against the nominal frame period.
- Declares lock after repeated periodic hits and flywheels through missed frames.
- Sits between the correlator/sync-detect pair and the frame deframer; provides the frame strobe and lock status.

---
 rtl/sync_pkg.sv | 6 +
 rtl/sync_win_cnt.sv | 49 ++++
 rtl/sync_acq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: state encoding and threshold type shared by the sync acquisition controller and detector wrapper
package sync_pkg;
  localparam int TRH_W = 12;
  typedef logic [TRH_W-1:0] trh_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, VERIFY = 2'd2, LOCK = 2'd3} state_e;
endpackage

// File: rtl/sync_win_cnt.sv
// sync_win_cnt: frame position counter with sop load, flywheel reload and acceptance-window flags.
// With SYNC_ACQ_PEAK_ALIGN_EN the position is referenced to the correlation peak instead of the sop.
module sync_win_cnt #(
  parameter int pFRAME_LEN = 2048,
  parameter int pTOL = 4,
  parameter int pEXT = 0,
  parameter int pPW = 13,
  parameter int pEW = 13
) (
  input  logic           iclk,
  input  logic           ireset,
  input  logic           ival,
  input  logic           isop,
  input  logic           iclr,
  input  logic           iload,
  input  logic           ifly,
  input  logic [6:0]     imax_addr,
  output logic           oin_win,
  output logic           oearly,
  output logic           oexpire,
  output logic [pEW-1:0] oerr
);
  localparam logic signed [pPW:0] LO = (pPW+1)'(pFRAME_LEN - pTOL);
  localparam logic signed [pPW:0] HI = (pPW+1)'(pFRAME_LEN + pTOL);
  localparam logic signed [pPW:0] NOM = (pPW+1)'(pFRAME_LEN);
  localparam logic [pPW-1:0] EXP = pPW'(pFRAME_LEN + pTOL + pEXT);
  localparam logic [pPW-1:0] FLY = pPW'(pTOL + 1 + pEXT);
  logic [pPW-1:0] pos_q, pos_d, corr;
  logic signed [pPW:0] pe;
`ifdef SYNC_ACQ_PEAK_ALIGN_EN
  assign corr = pPW'(pEXT) - pPW'(imax_addr);
`else
  logic unused_addr;
  assign unused_addr = ^imax_addr;
  assign corr = '0;
`endif
  // the load cycle is position corr itself, so a valid sample there already counts
  always_comb begin
    pe = $signed({1'b0, pos_q}) - $signed({1'b0, corr});
    pos_d = iclr ? '0 : iload ? corr + pPW'(ival) : ifly ? FLY : pos_q + pPW'(ival);
  end
  assign oin_win = pe >= LO && pe <= HI;
  assign oearly = pe < LO;
  assign oexpire = ival && !isop && pos_q == EXP;
  assign oerr = pEW'(pe - NOM);
  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) pos_q <= '0;
    else pos_q <= pos_d;
endmodule

// File: rtl/sync_acq_ctrl.sv
// sync_acq_ctrl: acquisition/tracking FSM that sequences the sync detector and flywheels frame timing.
// Define SYNC_ACQ_PEAK_ALIGN_EN to track the correlation peak position instead of the detector sop.
module sync_acq_ctrl
  import sync_pkg::*;
#(
  parameter int pDAT_W = 12,
  parameter int pFRAME_LEN = 2048,
  parameter int pTOL = 4,
  parameter int pVERIFY_N = 3,
  parameter int pMISS_N = 2,
  parameter int pWIND = 32
) (
  input  logic                                  iclk,
  input  logic                                  ireset,
  input  logic                                  ival,
  input  logic                                  istart,
  input  logic                                  iabort,
  input  logic [11:0]                           itrh_search,
  input  logic [11:0]                           itrh_track,
  input  logic                                  idet_sop,
  input  logic [pDAT_W-1:0]                     idet_mlvl,
  input  logic [6:0]                            idet_max_addr,
  output logic                                  odet_ena,
  output logic [11:0]                           odet_trh,
  output logic                                  oframe_sop,
  output logic                                  olocked,
  output logic                                  olost,
  output logic signed [$clog2(pFRAME_LEN)+1:0]  otime_err,
  output logic [pDAT_W-1:0]                     opeak_lvl,
  output logic [1:0]                            ostate
);
`ifdef SYNC_ACQ_PEAK_ALIGN_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif
  localparam int EXT = PEAK ? pWIND : 0;
  localparam int PW = $clog2(pFRAME_LEN + pTOL + EXT) + 1;
  localparam int EW = $clog2(pFRAME_LEN) + 2;
  localparam int CW = $clog2(pVERIFY_N + pMISS_N + 1);
  localparam logic [CW-1:0] VN = CW'(pVERIFY_N);
  localparam logic [CW-1:0] MN = CW'(pMISS_N);
  state_e state_q, state_d;
  logic [CW-1:0] hit_q, hit_d, miss_q, miss_d;
  logic [EW-1:0] err_q, err_d, win_err;
  logic [pDAT_W-1:0] peak_q, peak_d;
  trh_t trh_q, trh_d;
  logic ena_q, ena_d, locked_q, locked_d, frame_q, frame_d, lost_q, lost_d;
  logic load, fly, clr, in_win, early, expire;
  sync_win_cnt #(
    .pFRAME_LEN(pFRAME_LEN), .pTOL(pTOL), .pEXT(EXT), .pPW(PW), .pEW(EW)
  ) u_win (
    .iclk(iclk), .ireset(ireset), .ival(ival), .isop(idet_sop), .iclr(clr), .iload(load), .ifly(fly),
    .imax_addr(idet_max_addr), .oin_win(in_win), .oearly(early), .oexpire(expire), .oerr(win_err)
  );
  // any sop outside the window ends a VERIFY attempt; early ones in LOCK are simply ignored
  always_comb begin
    state_d = state_q;
    hit_d = hit_q;
    miss_d = miss_q;
    err_d = err_q;
    load = 1'b0;
    fly = 1'b0;
    clr = 1'b0;
    frame_d = 1'b0;
    lost_d = 1'b0;
    if (iabort) begin
      state_d = IDLE;
      hit_d = '0;
      miss_d = '0;
      clr = 1'b1;
    end else case (state_q)
      IDLE: begin
        clr = 1'b1;
        state_d = istart ? SEARCH : IDLE;
      end
      SEARCH: if (idet_sop) begin
        load = 1'b1;
        hit_d = CW'(1);
        state_d = VERIFY;
      end
      VERIFY: if (idet_sop && in_win) begin
        load = 1'b1;
        hit_d = hit_q + 1'b1;
        err_d = win_err;
        state_d = hit_q + 1'b1 == VN ? LOCK : VERIFY;
      end else if (idet_sop || expire) begin
        hit_d = '0;
        state_d = SEARCH;
      end
      LOCK: if (idet_sop && in_win) begin
        load = 1'b1;
        miss_d = '0;
        err_d = win_err;
        frame_d = 1'b1;
      end else if (expire) begin
        fly = 1'b1;
        frame_d = 1'b1;
        miss_d = miss_q + 1'b1;
        if (miss_q + 1'b1 == MN) begin
          state_d = SEARCH;
          lost_d = 1'b1;
          miss_d = '0;
          hit_d = '0;
        end
      end
    endcase
    peak_d = load ? idet_mlvl : peak_q;
    locked_d = state_d == LOCK;
    ena_d = state_d != IDLE;
    trh_d = state_d == LOCK ? itrh_track : state_d == IDLE ? '0 : itrh_search;
  end
  always_ff @(posedge iclk or negedge ireset)
    if (!ireset) begin
      state_q <= IDLE;
      hit_q <= '0;
      miss_q <= '0;
      err_q <= '0;
      peak_q <= '0;
      trh_q <= '0;
      ena_q <= 1'b0;
      locked_q <= 1'b0;
      frame_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      err_q <= err_d;
      peak_q <= peak_d;
      trh_q <= trh_d;
      ena_q <= ena_d;
      locked_q <= locked_d;
      frame_q <= frame_d;
      lost_q <= lost_d;
    end
  assign odet_ena = ena_q;
  assign odet_trh = trh_q;
  assign oframe_sop = frame_q;
  assign olocked = locked_q;
  assign olost = lost_q;
  assign otime_err = err_q;
  assign opeak_lvl = peak_q;
  assign ostate = state_q;
endmodule
